ahb_manager_arbiter: RTL and testbench
======================================

// Module: ahb_manager_arbiter
// PURPOSE
//  Shares a single AHB manager front end (bus_protocol request side: ren/wen/addr/wdata/strobe,
//  request_stall/rdata/error) between NUM_REQ requesters, e.g. I-fetch, D-access, debug.
//  Round-robin, non-preemptive: a grant is held until the granted transfer completes.
//  A forced one-cycle release gap follows every transfer so the manager returns to IDLE.
//  Sits between the requesters and ahb_manager.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2); pointer width PW = $clog2(NUM_REQ)
//  ADDR_W   32  address width
//  DATA_W   32  data width; strobe width is DATA_W/8
// PORTS
//  HCLK        in   1             clock, all state updates on rising edge
//  HRESET      in   1             asynchronous, active-high reset
//  req_ren     in   NUM_REQ       per-requester read request
//  req_wen     in   NUM_REQ       per-requester write request
//  req_addr    in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W  packed write data
//  req_strobe  in   NUM_REQ*DATA_W/8  packed byte strobes
//  req_stall   out  NUM_REQ       per-requester request_stall
//  req_rdata   out  DATA_W        shared read data (= m_rdata), valid only for the unstalled requester
//  req_error   out  NUM_REQ       per-requester error
//  gnt         out  NUM_REQ       one-hot current grant (zero when none)
//  m_ren/m_wen out  1             to manager
//  m_addr      out  ADDR_W        to manager
//  m_wdata     out  DATA_W        to manager
//  m_strobe    out  DATA_W/8      to manager
//  m_stall     in   1             manager request_stall
//  m_rdata     in   DATA_W        manager rdata
//  m_error     in   1             manager error
// BEHAVIOUR
//  Reset (HRESET=1, async): state=IDLE, rr_ptr=0, gnt=0. While reset is asserted:
//   m_ren=m_wen=0, m_addr/m_wdata/m_strobe=0, req_stall=all 1s, req_error=0.
//  Request of i: req_ren[i]|req_wen[i]. Winner: first requesting index scanning
//   rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//  IDLE:
//   - No request: all m_* = 0; gnt=0.
//   - Otherwise the winner is forwarded combinationally the same cycle (zero added latency),
//     gnt=onehot(winner), and winner is latched in gidx; next state GRANT.
//   - The winner's req_stall follows m_stall this cycle (the manager is stalling in its IDLE).
//  GRANT: forward gidx's ren/wen/addr/wdata/strobe to m_*.
//   - req_stall[gidx]=m_stall; req_error[gidx]=m_error; all others stall=1, error=0.
//   - Completion when m_stall=0: rr_ptr<=(gidx+1) mod NUM_REQ, next RELEASE.
//   - m_error=1 with m_stall=1: stay in GRANT and forward the error; the manager's ERROR cycle
//     follows, then completion.
//   - Granted requester drops ren&wen before completion (abort): next RELEASE; rr_ptr is advanced.
//  RELEASE (exactly 1 cycle): m_ren=m_wen=0, m_* data=0, all req_stall=1, gnt=0; next IDLE.
//   - New requests are only arbitrated in the following IDLE cycle.
//  Other requesters' requests are never forwarded while another holds the grant.
//  Pointer update occurs only on completion or abort, never in IDLE, so a waiting requester
//   is served within NUM_REQ-1 transfers.
//  ren and wen together: forwarded unchanged; the manager treats the request as a write.
//  Reset mid-GRANT: the transfer is dropped; state returns to IDLE immediately.
//  Throughput: at most one transfer per (manager latency + 1 RELEASE cycle).
// TESTING
//  1 Single: req_ren[0]=1 addr=0x100, manager stalls 1 cycle then returns rdata=0xCAFE0001
//    -> m_addr=0x100 in the same cycle as the request; req_stall[0]=0 with rdata on completion;
//       RELEASE follows; gnt back to 0.
//  2 Contention: req0 read and req1 write (wdata=0xA5A5A5A5, strobe=0xF) raised together,
//    rr_ptr=0 -> req0 served first; req1 m_wen asserts in the IDLE right after RELEASE;
//    rr_ptr=0 after both.
//  3 Fairness: req0 re-requests continuously while req1 is pending -> grants alternate 0,1,0,1;
//    never two consecutive grants to req0.
//  4 Error: granted req1 write, manager raises m_error=1 on a stall-high cycle
//    -> req_error[1]=1, req_error[0]=0, req_stall[0]=1 throughout; RELEASE after the
//       stall-low cycle.
//  5 Abort: req0 granted, drops ren before completion -> RELEASE next cycle, rr_ptr=1,
//    pending req1 granted in the next IDLE.
//  6 Reset mid-GRANT: assert HRESET asynchronously -> m_ren/m_wen=0, gnt=0 immediately;
//    after deassertion rr_ptr=0 and arbitration restarts from req0.

Source files
------------

// File: rtl/ahb_manager_arbiter.sv
// ahb_manager_arbiter: round-robin, non-preemptive sharing of one
// AHB manager request port between NUM_REQ requesters.
//
// Ports:
//   HCLK, HRESET          clock, async active-high reset
//   req_ren/req_wen       per-requester read/write request
//   req_addr/wdata/strobe packed per-requester request fields
//   req_stall/req_error   per-requester stall and error
//   req_rdata             shared read data (manager rdata)
//   gnt                   one-hot grant, zero when idle
//   m_ren/m_wen/m_addr    forwarded request to the manager
//   m_wdata/m_strobe      forwarded write data and strobes
//   m_stall/m_rdata/m_error  manager response
module ahb_manager_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [NUM_REQ-1:0]         req_ren,
  input  logic [NUM_REQ-1:0]         req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strobe,
  output logic [NUM_REQ-1:0]         req_stall,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [NUM_REQ-1:0]         req_error,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       m_ren,
  output logic                       m_wen,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_strobe,
  input  logic                       m_stall,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_error
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gidx;

  logic [NUM_REQ-1:0] w_req;
  logic               w_any;
  logic [PW-1:0]      w_win;
  logic [PW-1:0]      w_sel;
  logic               w_fwd;
  logic               w_done;

  logic [ADDR_W-1:0] w_addr [NUM_REQ];
  logic [DATA_W-1:0] w_wdat [NUM_REQ];
  logic [SW-1:0]     w_strb [NUM_REQ];

  function automatic logic [PW-1:0] f_wrap(
    input int v
  );
    return PW'(v % NUM_REQ);
  endfunction

  assign w_req = req_ren | req_wen;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdat[g] = req_wdata[g*DATA_W +: DATA_W];
    assign w_strb[g] = req_strobe[g*SW +: SW];
  end

  // Scan from the top down so the requester
  // closest to r_ptr is the last writer.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req[f_wrap(int'(r_ptr) + k)]) begin
        w_any = 1'b1;
        w_win = f_wrap(int'(r_ptr) + k);
      end
    end
  end

  // IDLE forwards the fresh winner with no
  // added latency; GRANT holds the latched one.
  assign w_sel = (r_state == S_GRANT) ? r_gidx
                                      : w_win;

  assign w_fwd = !HRESET &&
                 ((r_state == S_IDLE && w_any) ||
                  r_state == S_GRANT);

  // A dropped request ends the grant early.
  assign w_done = !w_req[r_gidx] || !m_stall;

  always_comb begin
    m_ren     = 1'b0;
    m_wen     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_strobe  = '0;
    req_stall = '1;
    req_error = '0;
    gnt       = '0;
    if (w_fwd) begin
      m_ren            = req_ren[w_sel];
      m_wen            = req_wen[w_sel];
      m_addr           = w_addr[w_sel];
      m_wdata          = w_wdat[w_sel];
      m_strobe         = w_strb[w_sel];
      req_stall[w_sel] = m_stall;
      gnt[w_sel]       = 1'b1;
      if (r_state == S_GRANT) begin
        req_error[w_sel] = m_error;
      end
    end
  end

  assign req_rdata = m_rdata;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gidx  <= w_win;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Error with stall high stays here until
          // the manager's stall-low error cycle.
          if (w_done) begin
            r_ptr   <= f_wrap(int'(r_gidx) + 1);
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// tb_ahb_manager_arbiter: directed checks of the
// round-robin AHB manager arbiter with NUM_REQ=2.
module tb_ahb_manager_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic [1:0]  req_ren;
  logic [1:0]  req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strobe;
  logic [1:0]  req_stall;
  logic [31:0] req_rdata;
  logic [1:0]  req_error;
  logic [1:0]  gnt;
  logic        m_ren;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strobe;
  logic        m_stall;
  logic [31:0] m_rdata;
  logic        m_error;

  int checks;
  int failures;

  ahb_manager_arbiter #(
    .NUM_REQ(2),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strobe(req_strobe),
    .req_stall (req_stall),
    .req_rdata (req_rdata),
    .req_error (req_error),
    .gnt       (gnt),
    .m_ren     (m_ren),
    .m_wen     (m_wen),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_strobe  (m_strobe),
    .m_stall   (m_stall),
    .m_rdata   (m_rdata),
    .m_error   (m_error)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    HRESET     = 1'b0;
    req_ren    = 2'b11;
    req_wen    = 2'b11;
    req_addr   = {32'h300, 32'h100};
    req_wdata  = {32'hA5A5A5A5, 32'h0};
    req_strobe = {4'hF, 4'h0};
    m_stall    = 1'b1;
    m_rdata    = '0;
    m_error    = 1'b0;
    #1 HRESET  = 1'b1;
    cyc();
    cyc();

    // reset holds everything quiet
    chk("rst_m_ren", m_ren, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_strobe", m_strobe, 0);
    chk("rst_stall", req_stall, 2'b11);
    chk("rst_error", req_error, 2'b00);
    chk("rst_gnt", gnt, 2'b00);

    // 1: single read by req0
    HRESET  = 1'b0;
    req_ren = 2'b01;
    req_wen = 2'b00;
    #1;
    chk("t1_idle_ren", m_ren, 1);
    chk("t1_idle_addr", m_addr, 32'h100);
    chk("t1_idle_gnt", gnt, 2'b01);
    chk("t1_idle_stall", req_stall, 2'b11);
    cyc();
    #1;
    chk("t1_g0_gnt", gnt, 2'b01);
    chk("t1_g0_stall", req_stall, 2'b11);
    cyc();
    m_stall = 1'b0;
    m_rdata = 32'hCAFE0001;
    #1;
    chk("t1_done_stall", req_stall, 2'b10);
    chk("t1_done_rdata", req_rdata, 32'hCAFE0001);
    chk("t1_done_gnt", gnt, 2'b01);
    cyc();
    req_ren = 2'b00;
    m_stall = 1'b1;
    m_rdata = '0;
    #1;
    chk("t1_rel_gnt", gnt, 2'b00);
    chk("t1_rel_ren", m_ren, 0);
    chk("t1_rel_stall", req_stall, 2'b11);
    cyc();
    #1;
    chk("t1_idle2_gnt", gnt, 2'b00);
    chk("t1_idle2_ren", m_ren, 0);

    // 2: contention from rr_ptr=0
    HRESET = 1'b1;
    #1;
    HRESET   = 1'b0;
    req_addr = {32'h300, 32'h200};
    req_ren  = 2'b01;
    req_wen  = 2'b10;
    #1;
    chk("t2_idle_gnt", gnt, 2'b01);
    chk("t2_idle_ren", m_ren, 1);
    chk("t2_idle_wen", m_wen, 0);
    chk("t2_idle_addr", m_addr, 32'h200);
    cyc();
    m_stall = 1'b0;
    m_rdata = 32'h11112222;
    #1;
    chk("t2_g0_stall", req_stall, 2'b10);
    chk("t2_g0_wen", m_wen, 0);
    chk("t2_g0_rdata", req_rdata, 32'h11112222);
    cyc();
    req_ren = 2'b00;
    m_stall = 1'b1;
    #1;
    chk("t2_rel_gnt", gnt, 2'b00);
    chk("t2_rel_wen", m_wen, 0);
    chk("t2_rel_stall", req_stall, 2'b11);
    cyc();
    #1;
    chk("t2_idle1_gnt", gnt, 2'b10);
    chk("t2_idle1_wen", m_wen, 1);
    chk("t2_idle1_addr", m_addr, 32'h300);
    chk("t2_idle1_wdata", m_wdata, 32'hA5A5A5A5);
    chk("t2_idle1_strb", m_strobe, 4'hF);
    chk("t2_idle1_stall", req_stall, 2'b11);
    cyc();
    m_stall = 1'b0;
    #1;
    chk("t2_g1_stall", req_stall, 2'b01);
    cyc();
    req_wen = 2'b00;
    m_stall = 1'b1;
    #1;
    chk("t2_rel1_gnt", gnt, 2'b00);
    cyc();

    // 3: fairness, both keep requesting
    for (int n = 0; n < 4; n++) begin
      req_ren = 2'b11;
      m_stall = 1'b1;
      #1;
      chk("t3_idle_gnt", gnt,
          (n % 2) ? 2'b10 : 2'b01);
      chk("t3_idle_addr", m_addr,
          (n % 2) ? 32'h300 : 32'h200);
      cyc();
      m_stall = 1'b0;
      #1;
      chk("t3_grant_stall", req_stall,
          (n % 2) ? 2'b01 : 2'b10);
      cyc();
      m_stall = 1'b1;
      if (n == 3) req_ren = 2'b00;
      #1;
      chk("t3_rel_gnt", gnt, 2'b00);
      cyc();
    end

    // 4: error on req1 write
    req_wen = 2'b10;
    #1;
    chk("t4_idle_gnt", gnt, 2'b10);
    chk("t4_idle_wen", m_wen, 1);
    cyc();
    req_ren = 2'b01;
    #1;
    chk("t4_g0_ren", m_ren, 0);
    chk("t4_g0_err", req_error, 2'b00);
    chk("t4_g0_stall", req_stall, 2'b11);
    cyc();
    m_error = 1'b1;
    #1;
    chk("t4_e1_err", req_error, 2'b10);
    chk("t4_e1_stall", req_stall, 2'b11);
    chk("t4_e1_gnt", gnt, 2'b10);
    cyc();
    m_stall = 1'b0;
    #1;
    chk("t4_e2_err", req_error, 2'b10);
    chk("t4_e2_stall", req_stall, 2'b01);
    cyc();
    m_stall = 1'b1;
    m_error = 1'b0;
    req_wen = 2'b00;
    #1;
    chk("t4_rel_gnt", gnt, 2'b00);
    chk("t4_rel_err", req_error, 2'b00);
    chk("t4_rel_stall", req_stall, 2'b11);
    cyc();

    // 5: abort by req0
    req_ren = 2'b11;
    #1;
    chk("t5_idle_gnt", gnt, 2'b01);
    chk("t5_idle_addr", m_addr, 32'h200);
    cyc();
    #1;
    chk("t5_g0_gnt", gnt, 2'b01);
    cyc();
    req_ren = 2'b10;
    #1;
    chk("t5_drop_ren", m_ren, 0);
    chk("t5_drop_gnt", gnt, 2'b01);
    cyc();
    req_ren = 2'b11;
    #1;
    chk("t5_rel_gnt", gnt, 2'b00);
    chk("t5_rel_ren", m_ren, 0);
    cyc();
    #1;
    chk("t5_next_gnt", gnt, 2'b10);
    chk("t5_next_addr", m_addr, 32'h300);
    cyc();
    #1;
    chk("t6_pre_gnt", gnt, 2'b10);
    chk("t6_pre_ren", m_ren, 1);

    // 6: async reset mid-GRANT
    #2 HRESET = 1'b1;
    #1;
    chk("t6_rst_ren", m_ren, 0);
    chk("t6_rst_wen", m_wen, 0);
    chk("t6_rst_gnt", gnt, 2'b00);
    chk("t6_rst_stall", req_stall, 2'b11);
    cyc();
    HRESET = 1'b0;
    #1;
    chk("t6_after_gnt", gnt, 2'b01);
    chk("t6_after_addr", m_addr, 32'h200);
    cyc();
    #1;
    chk("t6_grant_gnt", gnt, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
